sine_reader: RTL and testbench
==============================

# sine_reader

Consumer end of the phase-accumulator interface: takes the free-running angle stream produced by a voice's phase accumulator and turns it into a signed, volume-scaled sine sample. A quarter-wave table with mirroring is used, and a 3-stage pipeline handles the lookup. A gate state machine starts and stops the voice only at the positive-going zero crossing (phase wrap), so note-on and note-off never click. One instance sits after each voice's accumulator and feeds the mixer.

## Interface
- ANGLE_W, 8, angle width; top 2 bits are the quadrant, low ANGLE_W-2 bits are the index.
- SAMPLE_W, 8, signed output sample width; table full scale is 2^(SAMPLE_W-1)-1.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset; synchronous and active-high.
- angle  in  ANGLE_W  phase from the accumulator.
- angle_valid  in  1  angle is valid this cycle.
- gate  in  1  key held (note-on request).
- vol  in  4  volume; gain is (vol+1)/16.
- sample  out  SAMPLE_W  signed two's-complement sample.
- sample_valid  out  1  sample is valid this cycle.
- active  out  1  gate FSM is not IDLE.

## Operation
- **Quarter table:** Q[i] = round(127·sin(π/2·i/64)) for i = 0..63, with Q[64] = 127 implied. Defaults: ANGLE_W = 8, SAMPLE_W = 8. The table is a synthesised ROM.
- **Quadrant mapping** (q = angle[7:6], i = angle[5:0]):
  - q = 0: +Q[i]
  - q = 1: +Q[64-i]
  - q = 2: −Q[i]
  - q = 3: −Q[64-i]
- **Wrap detect:** wrap is true on a valid angle with q = 0 when prev_q = 3. prev_q updates only on angle_valid. Its reset value is 0.
- **Gate FSM states:** IDLE, PLAY, DRAIN. The FSM evaluates only on cycles with angle_valid.
  - IDLE → PLAY: gate=1 && wrap.
  - PLAY → DRAIN: gate=0.
  - DRAIN → PLAY: gate=1 (no wrap needed).
  - DRAIN → IDLE: wrap.
  - All other cases hold state.
- **Mute flag:** each sample carries a mute flag, computed from the next-state value. The wrap sample that enters PLAY is the first audible sample. The wrap sample that enters IDLE is the first muted sample.
- **Pipeline stage 1:** register q, the mirrored index (64-i for q odd, width ANGLE_W-1), the negate flag (q[1]), mute, and valid.
- **Pipeline stage 2:** ROM read gives magnitude m. Negate, mute, and valid carry forward.
- **Pipeline stage 3:**
  - s = negate ? −m : m.
  - p = s·(vol+1), a 13-bit signed product.
  - sample = p >>> 4, an arithmetic shift (floors toward −∞).
  - If mute, sample = 0.
  - vol is sampled at stage 3, not at input.
- **Valid stream:** sample_valid pulses for every valid angle, including muted ones, so the mixer sees a continuous stream.
- **active output:** registered. It is 1 in PLAY or DRAIN and reflects the FSM state after the stage-1 update.
- **Saturation:** none needed. |p>>>4| ≤ 127.

## Timing
- Latency: angle_valid at cycle N gives sample_valid at cycle N+3.
- Throughput: one sample per cycle. Gaps in angle_valid propagate as gaps in sample_valid, with no bubbles added.
- Reset values: sample = 0, sample_valid = 0, active = 0, FSM = IDLE, prev_q = 0, all pipeline valids = 0.
- Reset mid-stream: in-flight samples are discarded, with no sample_valid for 3 cycles after rst drops. A note that was playing restarts only at the next wrap with gate=1.
- gate and vol may change on any cycle. gate is only observed on valid cycles.
- Simultaneous events:
  - gate falls on the wrap cycle while in PLAY: the state goes to DRAIN, not IDLE. A full additional period plays.
  - gate rises and falls between two valid angles: it is not seen.
  - Several consecutive q = 0 angles after one q = 3: only the first is a wrap.

## Test plan
- **Table mapping:** gate held, in PLAY, vol=15, feed angles 0x00, 0x20, 0x40, 0x60, 0xA0, 0xC0, one per cycle. Required samples 3 cycles later: 0, 90, 127, 90, −90, −127.
- **Volume scaling:** in PLAY, vol=7, angles 0x40 and 0xA0. Required samples: 63 and −45.
- **Note-on alignment:** gate=1 in IDLE, sweep angle 0x80 → 0xFF → 0x00 step 1. Required: samples stay 0 with sample_valid=1 until the angle 0x00 sample; active rises on the cycle after 0x00 is accepted.
- **Note-off alignment:** drop gate mid-period at angle 0x50, keep sweeping. Required: audible samples continue through 0xFF, sample for the next 0x00 is 0, active falls; then regate in DRAIN before the wrap returns to PLAY with no muted sample.
- **Reset and gaps:** assert rst for 1 cycle mid-stream. Required: sample_valid is low for 3 cycles after rst drops, sample = 0, active = 0. Separately, an angle_valid pattern 1,0,1,1 gives sample_valid 1,0,1,1 delayed by 3 cycles.

Source files
------------

// File: rtl/sine_reader.sv
// Voice sine reader: angle stream in, signed volume-scaled sine sample out.
// A quarter-wave ROM is mirrored across the four quadrants. A gate FSM starts
// and stops the voice only at the positive-going zero crossing (phase wrap),
// so note-on and note-off never click.
//
//   state | meaning
//   IDLE  | voice silent, waiting for gate=1 on a wrap
//   PLAY  | voice audible, gate held
//   DRAIN | gate released, still audible until the next wrap
//
// The ROM contents are built for the default ANGLE_W=8 / SAMPLE_W=8.
module sine_reader #(
  parameter int ANGLE_W  = 8,
  parameter int SAMPLE_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ANGLE_W-1:0]  angle,
  input  logic                angle_valid,
  input  logic                gate,
  input  logic [3:0]          vol,
  output logic [SAMPLE_W-1:0] sample,
  output logic                sample_valid,
  output logic                active
);

  localparam int IDX_W = ANGLE_W - 1;   // holds 0..2^(ANGLE_W-2) inclusive
  localparam int MAG_W = SAMPLE_W - 1;
  localparam int P_W   = SAMPLE_W + 5;  // signed magnitude times 5-bit gain
  localparam logic [IDX_W-1:0] QUARTER = IDX_W'(2 ** (ANGLE_W - 2));

  // round(127*sin(pi/2*i/64)), i = 0..64
  localparam logic [MAG_W-1:0] QTAB [0:64] = '{
    7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
    7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
    7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
    7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
    7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
    7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
    7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127,
    7'd127
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          prev_quad_q, prev_quad_d;
  logic                active_q, active_d;

  logic [IDX_W-1:0]    idx1_q, idx1_d;
  logic                neg1_q, neg1_d;
  logic                mute1_q, mute1_d;
  logic                vld1_q, vld1_d;

  logic [MAG_W-1:0]    mag2_q, mag2_d;
  logic                neg2_q, neg2_d;
  logic                mute2_q, mute2_d;
  logic                vld2_q, vld2_d;

  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                sample_valid_q, sample_valid_d;

  logic [1:0]          quad;
  logic [ANGLE_W-3:0]  idx_in;
  logic                wrap;

  // Gate FSM: advances only on valid angles; wrap = first q=0 after a q=3
  always_comb begin
    quad        = angle[ANGLE_W-1 -: 2];
    idx_in      = angle[ANGLE_W-3:0];
    wrap        = angle_valid && (quad == 2'd0) && (prev_quad_q == 2'd3);
    state_d     = state_q;
    prev_quad_d = prev_quad_q;
    if (angle_valid) begin
      prev_quad_d = quad;
      case (state_q)
        IDLE:    if (gate && wrap) state_d = PLAY;
        PLAY:    if (!gate)        state_d = DRAIN;
        DRAIN: begin
          if (gate)      state_d = PLAY;
          else if (wrap) state_d = IDLE;
        end
        default:                   state_d = IDLE;
      endcase
    end
    active_d = (state_d != IDLE);
  end

  // Datapath: stage 1 mirrors the index, stage 2 reads the ROM, stage 3 scales
  always_comb begin
    logic [4:0]             gain;
    logic signed [P_W-1:0]  mag_ext;
    logic signed [P_W-1:0]  gain_ext;
    logic signed [P_W-1:0]  s_val;
    logic signed [P_W-1:0]  prod;

    idx1_d  = quad[0] ? (QUARTER - {1'b0, idx_in}) : {1'b0, idx_in};
    neg1_d  = quad[1];
    mute1_d = (state_d == IDLE);
    vld1_d  = angle_valid;

    mag2_d  = QTAB[idx1_q];
    neg2_d  = neg1_q;
    mute2_d = mute1_q;
    vld2_d  = vld1_q;

    gain     = {1'b0, vol} + 5'd1;
    mag_ext  = {{(P_W-MAG_W){1'b0}}, mag2_q};
    gain_ext = {{(P_W-5){1'b0}}, gain};
    s_val    = neg2_q ? -mag_ext : mag_ext;
    prod     = s_val * gain_ext;

    sample_d       = (vld2_q && !mute2_q) ? SAMPLE_W'(prod >>> 4) : '0;
    sample_valid_d = vld2_q;
  end

  // All state registers, synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      prev_quad_q    <= 2'd0;
      active_q       <= 1'b0;
      idx1_q         <= '0;
      neg1_q         <= 1'b0;
      mute1_q        <= 1'b0;
      vld1_q         <= 1'b0;
      mag2_q         <= '0;
      neg2_q         <= 1'b0;
      mute2_q        <= 1'b0;
      vld2_q         <= 1'b0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      prev_quad_q    <= prev_quad_d;
      active_q       <= active_d;
      idx1_q         <= idx1_d;
      neg1_q         <= neg1_d;
      mute1_q        <= mute1_d;
      vld1_q         <= vld1_d;
      mag2_q         <= mag2_d;
      neg2_q         <= neg2_d;
      mute2_q        <= mute2_d;
      vld2_q         <= vld2_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign active       = active_q;

endmodule

// File: tb/tb_sine_reader.sv
// Bench for sine_reader: reference model built from sine math and gate rules,
// table-driven mapping/volume vectors, directed gate/reset/gap sequences and
// a randomized stream.
module tb_sine_reader;

  localparam int N = 4096;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] angle;
  logic       angle_valid;
  logic       gate;
  logic [3:0] vol;
  logic [7:0] sample;
  logic       sample_valid;
  logic       active;

  always #5 clk = ~clk;

  sine_reader #(.ANGLE_W(8), .SAMPLE_W(8)) dut (
    .clk(clk), .rst(rst), .angle(angle), .angle_valid(angle_valid),
    .gate(gate), .vol(vol), .sample(sample), .sample_valid(sample_valid),
    .active(active)
  );

  typedef struct {
    int angle;
    int vol;
    int exp;
  } vec_t;

  int qtab [0:64];
  int e_vld [N];
  int e_val [N];
  int e_mute [N];
  int e_ang [N];
  int last_out [256];
  int outq [$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int post = 100;
  bit m_on = 0;
  bit m_rel = 0;
  int m_prev = 0;
  logic last_sv;

  task automatic chk(input string nm, input logic signed [31:0] got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d at cycle %0d", nm, got, exp, cyc);
    end
  endtask

  function automatic int ref_val(input int a);
    int q, i, m;
    q = (a >> 6) & 3;
    i = a & 63;
    m = (q % 2 == 1) ? qtab[64 - i] : qtab[i];
    return (q >= 2) ? -m : m;
  endfunction

  // one clock: drive inputs, advance the model, check outputs after the edge
  task automatic step(input bit r, input bit av, input int a, input bit g, input int v);
    int t, ti, ix, ev, es, q;
    bit wrap;
    t  = cyc;
    ti = t % N;
    ix = (t + N - 2) % N;
    rst = r; angle_valid = av; angle = 8'(a); gate = g; vol = 4'(v);
    e_vld[ti] = 0;
    e_ang[ti] = a & 255;
    if (r) begin
      m_on = 0; m_rel = 0; m_prev = 0; post = 0;
      e_vld[(t + N - 1) % N] = 0;
      e_vld[ix] = 0;
    end else begin
      post++;
      if (av) begin
        q = (a >> 6) & 3;
        wrap = (q == 0) && (m_prev == 3);
        if (!m_on) begin
          if (g && wrap) begin m_on = 1; m_rel = 0; end
        end else if (!m_rel) begin
          if (!g) m_rel = 1;
        end else begin
          if (g) m_rel = 0;
          else if (wrap) begin m_on = 0; m_rel = 0; end
        end
        m_prev = q;
        e_vld[ti]  = 1;
        e_val[ti]  = ref_val(a & 255);
        e_mute[ti] = m_on ? 0 : 1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    ev = (!r && t >= 2) ? e_vld[ix] : 0;
    es = 0;
    if (ev != 0 && e_mute[ix] == 0)
      es = $rtoi($floor(real'(e_val[ix] * (v + 1)) / 16.0));
    chk("sample_valid", sample_valid, ev);
    if (ev != 0 || post <= 2) chk("sample", $signed(sample), es);
    chk("active", active, m_on);
    if (sample_valid === 1'b1 && ev != 0) begin
      last_out[e_ang[ix]] = $signed(sample);
      outq.push_back($signed(sample));
    end
    last_sv = sample_valid;
  endtask

  task automatic sweep(input int start, input int n, input bit g, input int v);
    for (int k = 0; k < n; k++) step(0, 1, (start + k) & 255, g, v);
  endtask

  task automatic clear_last();
    for (int k = 0; k < 256; k++) last_out[k] = 999;
  endtask

  initial begin
    vec_t vecs [8];
    int nz, ang, obs [7];
    bit g;
    int pat [7];

    for (int i = 0; i <= 64; i++)
      qtab[i] = $rtoi($floor(127.0 * $sin(3.14159265358979 * i / 128.0) + 0.5));

    vecs[0] = '{8'h00, 15, 0};
    vecs[1] = '{8'h20, 15, 90};
    vecs[2] = '{8'h40, 15, 127};
    vecs[3] = '{8'h60, 15, 90};
    vecs[4] = '{8'hA0, 15, -90};
    vecs[5] = '{8'hC0, 15, -127};
    vecs[6] = '{8'h40, 7, 63};
    vecs[7] = '{8'hA0, 7, -45};

    rst = 1; angle_valid = 0; angle = 0; gate = 0; vol = 0;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // table mapping and volume scaling, entered into PLAY through a wrap
    step(0, 1, 8'hC0, 1, 15);
    step(0, 1, 8'h00, 1, 15);
    chk("enter_play", active, 1);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 15);
    outq.delete();
    for (int k = 0; k < 8; k++) begin
      step(0, 1, vecs[k].angle, 1, vecs[k].vol);
      if (k == 7 || vecs[k + 1].vol != vecs[k].vol)
        for (int f = 0; f < 3; f++) step(0, 0, 0, 1, vecs[k].vol);
    end
    chk("tbl_count", outq.size(), 8);
    for (int k = 0; k < 8 && k < outq.size(); k++) chk("tbl_sample", outq[k], vecs[k].exp);

    // note-on alignment
    step(1, 0, 0, 0, 15);
    clear_last();
    sweep(8'h80, 128, 1, 15);
    chk("noteon_pre_active", active, 0);
    step(0, 1, 8'h00, 1, 15);
    chk("noteon_active", active, 1);
    sweep(8'h01, 8'h4F, 1, 15);
    nz = 0;
    for (int k = 8'h80; k <= 8'hFF; k++) if (last_out[k] != 0) nz++;
    chk("noteon_muted_nonzero", nz, 0);
    chk("noteon_first", last_out[8'h00], 0);
    chk("noteon_second", last_out[8'h01], 3);

    // note-off alignment
    clear_last();
    sweep(8'h50, 176, 0, 15);
    chk("noteoff_drain_active", active, 1);
    step(0, 1, 8'h00, 0, 15);
    chk("noteoff_active", active, 0);
    sweep(8'h01, 3, 0, 15);
    chk("noteoff_audible", last_out[8'h51], 116);
    chk("noteoff_last", last_out[8'hFF], -3);
    chk("noteoff_muted", last_out[8'h01], 0);

    // regate while draining returns to PLAY without a muted sample
    sweep(8'h04, 252, 1, 15);
    step(0, 1, 8'h00, 1, 15);
    sweep(8'h01, 8'h4F, 1, 15);
    sweep(8'h50, 8'h40, 0, 15);
    chk("regate_drain", active, 1);
    clear_last();
    sweep(8'h90, 8'h70, 1, 15);
    sweep(8'h00, 6, 1, 15);
    chk("regate_active", active, 1);
    chk("regate_ff", last_out[8'hFF], -3);
    chk("regate_01", last_out[8'h01], 3);

    // gate falling on the wrap cycle while playing gives DRAIN, a full extra period
    sweep(8'h06, 250, 1, 15);
    step(0, 1, 8'h00, 0, 15);
    chk("wrapfall_drain", active, 1);
    sweep(8'h01, 255, 0, 15);
    chk("wrapfall_still", active, 1);
    step(0, 1, 8'h00, 0, 15);
    chk("wrapfall_idle", active, 0);

    // gate pulse between valid angles is not seen
    step(0, 1, 8'hC0, 0, 9);
    step(0, 0, 8'h00, 1, 9);
    step(0, 1, 8'h00, 0, 9);
    chk("gate_pulse", active, 0);

    // only the first q=0 after q=3 is a wrap
    step(0, 1, 8'hC0, 0, 9);
    step(0, 1, 8'h00, 0, 9);
    step(0, 1, 8'h01, 1, 9);
    step(0, 1, 8'h02, 1, 9);
    chk("second_q0", active, 0);
    step(0, 1, 8'hC0, 1, 9);
    step(0, 1, 8'h00, 1, 9);
    chk("after_wrap", active, 1);

    // reset mid-stream
    sweep(8'h01, 10, 1, 12);
    step(1, 1, 8'h10, 1, 12);
    chk("rst_sv0", sample_valid, 0);
    step(0, 1, 8'h11, 1, 12);
    chk("rst_sv1", sample_valid, 0);
    step(0, 1, 8'h12, 1, 12);
    chk("rst_sv2", sample_valid, 0);
    chk("rst_sample", $signed(sample), 0);
    chk("rst_active", active, 0);
    step(0, 1, 8'h13, 1, 12);
    chk("rst_sv3", sample_valid, 1);

    // valid gaps propagate unchanged
    pat = '{1, 0, 1, 1, 0, 0, 0};
    for (int k = 0; k < 7; k++) begin
      step(0, pat[k][0], 8'h20 + k, 1, 5);
      obs[k] = int'(last_sv);
    end
    for (int k = 0; k < 4; k++) chk("gap_pattern", obs[k + 2], pat[k]);

    // randomized stream against the model
    ang = 0;
    g = 1;
    for (int k = 0; k < 3000; k++) begin
      ang = (ang + int'($urandom_range(0, 20))) % 256;
      if ($urandom_range(0, 49) == 0) g = ~g;
      step(($urandom_range(0, 399) == 0), ($urandom_range(0, 3) != 0), ang, g,
           int'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
